// File: rtl/sram_access_sequencer.sv
// rtl/sram_access_sequencer.sv - timed precharge/wordline/done sequencer feeding control_decoder
// Optional write-verify read-back pass is compiled in with SRAM_SEQ_WVERIFY_EN.
module sram_access_sequencer #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] dec_addr,
  output logic              dec_enable,
  output logic              precharge,
  output logic              write_en,
  output logic [DATA_W-1:0] bl_wdata,
  output logic              sense_en,
  input  logic [DATA_W-1:0] sense_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              wr_err
);

  localparam int MAX_CYC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {IDLE, PRE, WL, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              verify_q, verify_d;
  logic [ADDR_W-1:0] dec_addr_q, dec_addr_d;
  logic [DATA_W-1:0] bl_wdata_q, bl_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              dec_enable_q, dec_enable_d;
  logic              precharge_q, precharge_d;
  logic              write_en_q, write_en_d;
  logic              sense_en_q, sense_en_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              wr_err_q, wr_err_d;
  logic              accept;
  logic              sensing;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // A wordline phase senses for reads and for the read-back pass of a verified write.
  assign sensing   = !we_q || verify_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    verify_d      = verify_q;
    dec_addr_d    = dec_addr_q;
    bl_wdata_d    = bl_wdata_q;
    rdata_d       = rdata_q;
    dec_enable_d  = 1'b0;
    precharge_d   = 1'b0;
    write_en_d    = 1'b0;
    sense_en_d    = 1'b0;
    rdata_valid_d = 1'b0;
    wr_err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = PRE;
          cnt_d       = PRE_LOAD;
          we_d        = req_we;
          verify_d    = 1'b0;
          dec_addr_d  = req_addr;
          precharge_d = 1'b1;
          if (req_we) bl_wdata_d = req_wdata;
        end
      end
      PRE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d      = WL;
          cnt_d        = WL_LOAD;
          dec_enable_d = 1'b1;
          write_en_d   = we_q && !verify_q;
          sense_en_d   = sensing && (WL_CYCLES == 1);
        end else begin
          cnt_d       = cnt_q - CNT_ONE;
          precharge_d = 1'b1;
        end
      end
      WL: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d        = cnt_q - CNT_ONE;
          dec_enable_d = 1'b1;
          write_en_d   = we_q && !verify_q;
          sense_en_d   = sensing && (cnt_q == CNT_ONE);
        end else begin
`ifdef SRAM_SEQ_WVERIFY_EN
          if (we_q && !verify_q) begin
            state_d     = PRE;
            cnt_d       = PRE_LOAD;
            verify_d    = 1'b1;
            precharge_d = 1'b1;
          end else begin
            state_d = DONE;
            if (verify_q) begin
              wr_err_d = (sense_data != bl_wdata_q);
            end else begin
              rdata_d       = sense_data;
              rdata_valid_d = 1'b1;
            end
          end
`else
          state_d = DONE;
          if (!we_q) begin
            rdata_d       = sense_data;
            rdata_valid_d = 1'b1;
          end
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      verify_q      <= 1'b0;
      dec_addr_q    <= '0;
      bl_wdata_q    <= '0;
      rdata_q       <= '0;
      dec_enable_q  <= 1'b0;
      precharge_q   <= 1'b0;
      write_en_q    <= 1'b0;
      sense_en_q    <= 1'b0;
      rdata_valid_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      verify_q      <= verify_d;
      dec_addr_q    <= dec_addr_d;
      bl_wdata_q    <= bl_wdata_d;
      rdata_q       <= rdata_d;
      dec_enable_q  <= dec_enable_d;
      precharge_q   <= precharge_d;
      write_en_q    <= write_en_d;
      sense_en_q    <= sense_en_d;
      rdata_valid_q <= rdata_valid_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign dec_addr    = dec_addr_q;
  assign dec_enable  = dec_enable_q;
  assign precharge   = precharge_q;
  assign write_en    = write_en_q;
  assign bl_wdata    = bl_wdata_q;
  assign sense_en    = sense_en_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wr_err      = wr_err_q;

endmodule
